// File: rtl/ub_arb_if.sv
// Unified-buffer arbiter bus: two requester handshakes plus the buffer
// command/address lines. slave = arbiter side, master = requesters and buffer.
interface ub_arb_if #(
   parameter int ADDRESS_SIZE = 10
);
   logic                    cmp_req_valid;
   logic                    cmp_req_ready;
   logic                    cmp_req_write;
   logic [ADDRESS_SIZE-1:0] cmp_req_addr;
   logic                    cmp_rsp_valid;
   logic                    fifo_req_valid;
   logic                    fifo_req_ready;
   logic                    fifo_req_write;
   logic [ADDRESS_SIZE-1:0] fifo_req_addr;
   logic                    fifo_req_section;
   logic                    fifo_rsp_valid;
   logic                    rsp_err;
   logic                    err_sticky;
   logic                    ub_we;
   logic                    ub_re;
   logic                    ub_compute_en;
   logic                    ub_fifo_en;
   logic                    ub_section;
   logic [ADDRESS_SIZE-1:0] ub_address;
   logic                    ub_done;

   modport slave (
      input  cmp_req_valid, cmp_req_write, cmp_req_addr,
      input  fifo_req_valid, fifo_req_write, fifo_req_addr, fifo_req_section,
      input  ub_done,
      output cmp_req_ready, cmp_rsp_valid, fifo_req_ready, fifo_rsp_valid,
      output rsp_err, err_sticky,
      output ub_we, ub_re, ub_compute_en, ub_fifo_en, ub_section, ub_address
   );

   modport master (
      output cmp_req_valid, cmp_req_write, cmp_req_addr,
      output fifo_req_valid, fifo_req_write, fifo_req_addr, fifo_req_section,
      output ub_done,
      input  cmp_req_ready, cmp_rsp_valid, fifo_req_ready, fifo_rsp_valid,
      input  rsp_err, err_sticky,
      input  ub_we, ub_re, ub_compute_en, ub_fifo_en, ub_section, ub_address
   );
endinterface

// File: rtl/ub_arbiter.sv
// Unified-buffer sequencer and two-requester round-robin arbiter.
// Requester 0 = compute (word access), requester 1 = host FIFO (byte section).
// IDLE -> ISSUE (one command pulse) -> WAIT (for ub_done) -> response pulse.
// Optional macro UB_ARB_TIMEOUT_EN: abort WAIT after TIMEOUT_CYCLES cycles
// with rsp_err and a sticky error flag.
module ub_arbiter #(
   parameter int BUFFER_SIZE    = 1024,
   parameter int ADDRESS_SIZE   = $clog2(BUFFER_SIZE),
   parameter int TIMEOUT_CYCLES = 15
)(
   input logic     clk,
   input logic     rst_n,
   ub_arb_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t                  state_q;
   logic                    owner_q;      // 1 = FIFO owns the access in flight
   logic                    last_q;       // 1 = FIFO was granted last
   logic                    we_q, re_q, cen_q, fen_q, sect_q;
   logic [ADDRESS_SIZE-1:0] addr_q;
   logic                    cmp_rsp_q, fifo_rsp_q;
   logic                    cmp_rdy, fifo_rdy, is_idle;

`ifdef UB_ARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) < 4) ? 4 : $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] cnt_q;
   logic             rsp_err_q, sticky_q;
`endif

   // Ties go to whoever was not granted last; ready only exists in IDLE.
   assign is_idle  = (state_q == S_IDLE);
   assign cmp_rdy  = is_idle & bus.cmp_req_valid  & (~bus.fifo_req_valid | last_q);
   assign fifo_rdy = is_idle & bus.fifo_req_valid & (~bus.cmp_req_valid  | ~last_q);

   // Sequencer: all buffer-facing and response outputs are registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         owner_q    <= 1'b0;
         last_q     <= 1'b1;
         we_q       <= 1'b0;
         re_q       <= 1'b0;
         cen_q      <= 1'b0;
         fen_q      <= 1'b0;
         sect_q     <= 1'b0;
         addr_q     <= '0;
         cmp_rsp_q  <= 1'b0;
         fifo_rsp_q <= 1'b0;
`ifdef UB_ARB_TIMEOUT_EN
         cnt_q      <= '0;
         rsp_err_q  <= 1'b0;
         sticky_q   <= 1'b0;
`endif
      end else begin
         cmp_rsp_q  <= 1'b0;
         fifo_rsp_q <= 1'b0;
`ifdef UB_ARB_TIMEOUT_EN
         rsp_err_q  <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (cmp_rdy || fifo_rdy) begin
                  state_q <= S_ISSUE;
                  owner_q <= fifo_rdy;
                  last_q  <= fifo_rdy;
                  we_q    <= fifo_rdy ? bus.fifo_req_write : bus.cmp_req_write;
                  re_q    <= fifo_rdy ? ~bus.fifo_req_write : ~bus.cmp_req_write;
                  cen_q   <= ~fifo_rdy;
                  fen_q   <= fifo_rdy;
                  addr_q  <= fifo_rdy ? bus.fifo_req_addr : bus.cmp_req_addr;
                  sect_q  <= fifo_rdy & bus.fifo_req_section;
               end
            end
            S_ISSUE: begin
               state_q <= S_WAIT;
               we_q    <= 1'b0;
               re_q    <= 1'b0;
               cen_q   <= 1'b0;
               fen_q   <= 1'b0;
`ifdef UB_ARB_TIMEOUT_EN
               cnt_q   <= '0;
`endif
            end
            S_WAIT: begin
               if (bus.ub_done) begin
                  state_q    <= S_IDLE;
                  cmp_rsp_q  <= ~owner_q;
                  fifo_rsp_q <= owner_q;
               end
`ifdef UB_ARB_TIMEOUT_EN
               else if (cnt_q == CNT_LAST) begin
                  state_q    <= S_IDLE;
                  cmp_rsp_q  <= ~owner_q;
                  fifo_rsp_q <= owner_q;
                  rsp_err_q  <= 1'b1;
                  sticky_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
`endif
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.cmp_req_ready  = cmp_rdy;
   assign bus.fifo_req_ready = fifo_rdy;
   assign bus.cmp_rsp_valid  = cmp_rsp_q;
   assign bus.fifo_rsp_valid = fifo_rsp_q;
   assign bus.ub_we          = we_q;
   assign bus.ub_re          = re_q;
   assign bus.ub_compute_en  = cen_q;
   assign bus.ub_fifo_en     = fen_q;
   assign bus.ub_section     = sect_q;
   assign bus.ub_address     = addr_q;
`ifdef UB_ARB_TIMEOUT_EN
   assign bus.rsp_err        = rsp_err_q;
   assign bus.err_sticky     = sticky_q;
`else
   assign bus.rsp_err        = 1'b0;
   assign bus.err_sticky     = 1'b0;
`endif
endmodule

// File: tb/tb_ub_arbiter.sv
// Directed bench for ub_arbiter: vector table for single accesses plus
// hand-written contention, async-reset, stalled-buffer and timeout sequences.
module tb_ub_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ub_arb_if #(.ADDRESS_SIZE(10)) bus();
   ub_arbiter #(.BUFFER_SIZE(1024)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int errors = 0;
   int checks = 0;

   // Buffer model: done pulses done_delay cycles after the command is seen.
   int   done_delay = 1;
   logic no_done    = 1'b0;
   int   pend       = 0;
   always @(negedge clk) begin
      bus.ub_done = 1'b0;
      if (!rst_n) pend = 0;
      else begin
         if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) bus.ub_done = 1'b1;
         end
         if ((bus.ub_we || bus.ub_re) && !no_done) pend = done_delay;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.cmp_req_valid = 0; bus.cmp_req_write = 0; bus.cmp_req_addr = '0;
      bus.fifo_req_valid = 0; bus.fifo_req_write = 0; bus.fifo_req_addr = '0;
      bus.fifo_req_section = 0;
   endtask

   typedef struct {
      logic       fifo;
      logic       wr;
      logic [9:0] addr;
      logic       sect;
      logic       e_we, e_re, e_cen, e_fen, e_sect;
      logic [9:0] e_addr;
   } vec_t;

   vec_t vt[5];
   string gseq;

   initial begin
      //          fifo wr addr    sect we re cen fen sect addr
      vt[0] = '{1'b0, 1'b1, 10'h005, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h005};
      vt[1] = '{1'b1, 1'b0, 10'h3FF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 10'h3FF};
      vt[2] = '{1'b0, 1'b0, 10'h2AA, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h2AA};
      vt[3] = '{1'b1, 1'b1, 10'h001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h001};
      vt[4] = '{1'b1, 1'b1, 10'h200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'h200};

      idle_inputs();
      bus.ub_done = 0;
      repeat (2) @(negedge clk);
      chk("rst_we", bus.ub_we, 0);
      chk("rst_re", bus.ub_re, 0);
      chk("rst_en", {bus.ub_compute_en, bus.ub_fifo_en}, 0);
      chk("rst_addr", bus.ub_address, 0);
      chk("rst_rsp", {bus.cmp_rsp_valid, bus.fifo_rsp_valid, bus.rsp_err, bus.err_sticky}, 0);
      rst_n = 1;
      @(negedge clk);

      // Single accesses from the table; sections on the compute path are ignored.
      for (int i = 0; i < 5; i++) begin
         bus.fifo_req_section = vt[i].sect;
         if (vt[i].fifo) begin
            bus.fifo_req_valid = 1; bus.fifo_req_write = vt[i].wr; bus.fifo_req_addr = vt[i].addr;
         end else begin
            bus.cmp_req_valid = 1; bus.cmp_req_write = vt[i].wr; bus.cmp_req_addr = vt[i].addr;
         end
         #1;
         chk($sformatf("v%0d_ready", i), {bus.cmp_req_ready, bus.fifo_req_ready}, vt[i].fifo ? 2'b01 : 2'b10);
         @(negedge clk);
         idle_inputs();
         bus.cmp_req_addr = 10'h111;  // post-accept changes must not matter
         #1;
         chk($sformatf("v%0d_cmd", i), {bus.ub_we, bus.ub_re, bus.ub_compute_en, bus.ub_fifo_en, bus.ub_section},
             {vt[i].e_we, vt[i].e_re, vt[i].e_cen, vt[i].e_fen, vt[i].e_sect});
         chk($sformatf("v%0d_addr", i), bus.ub_address, vt[i].e_addr);
         @(negedge clk); #1;
         chk($sformatf("v%0d_wait", i), {bus.ub_we, bus.ub_re, bus.ub_compute_en, bus.ub_fifo_en,
             bus.cmp_rsp_valid, bus.fifo_rsp_valid}, 0);
         chk($sformatf("v%0d_hold", i), {bus.ub_section, bus.ub_address}, {vt[i].e_sect, vt[i].e_addr});
         @(negedge clk); #1;
         chk($sformatf("v%0d_rsp", i), {bus.cmp_rsp_valid, bus.fifo_rsp_valid, bus.rsp_err},
             vt[i].fifo ? 3'b010 : 3'b100);
         @(negedge clk); #1;
         chk($sformatf("v%0d_rsp_off", i), {bus.cmp_rsp_valid, bus.fifo_rsp_valid}, 0);
      end

      // Contention from reset: expect C,F,C,F and never both readies.
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      gseq = "";
      bus.cmp_req_valid = 1; bus.fifo_req_valid = 1;
      bus.cmp_req_addr = 10'h010; bus.fifo_req_addr = 10'h020;
      for (int c = 0; c < 12; c++) begin
         #1;
         chk($sformatf("cont_excl%0d", c), bus.cmp_req_ready & bus.fifo_req_ready, 0);
         if (bus.cmp_req_ready) gseq = {gseq, "C"};
         if (bus.fifo_req_ready) gseq = {gseq, "F"};
         @(negedge clk);
      end
      idle_inputs();
      checks++;
      if (gseq != "CFCF") begin
         errors++;
         $display("FAIL cont_order: got %s expected CFCF", gseq);
      end
      repeat (4) @(negedge clk);

      // Async reset in ISSUE after a compute grant; first tie afterwards is compute.
      bus.cmp_req_valid = 1; bus.cmp_req_write = 1; bus.cmp_req_addr = 10'h0AB;
      @(negedge clk);
      idle_inputs();
      #1;
      chk("ar_issue", bus.ub_we, 1);
      rst_n = 0;
      #1;
      chk("ar_zero", {bus.ub_we, bus.ub_re, bus.ub_compute_en, bus.ub_fifo_en, bus.ub_section,
          bus.ub_address, bus.cmp_rsp_valid, bus.fifo_rsp_valid}, 0);
      @(negedge clk);
      rst_n = 1;
      bus.cmp_req_valid = 1; bus.fifo_req_valid = 1;
      #1;
      chk("ar_first", {bus.cmp_req_ready, bus.fifo_req_ready}, 2'b10);
      @(negedge clk);
      idle_inputs();
      repeat (4) @(negedge clk);

      // Stalled buffer: done 6 cycles after the command.
      done_delay = 6;
      bus.cmp_req_valid = 1; bus.cmp_req_write = 0; bus.cmp_req_addr = 10'h155;
      #1;
      chk("st_ready", bus.cmp_req_ready, 1);
      @(negedge clk);                   // T1 ISSUE
      bus.cmp_req_valid = 0;
      bus.fifo_req_valid = 1; bus.fifo_req_write = 0; bus.fifo_req_addr = 10'h0F0;
      for (int k = 2; k <= 7; k++) begin
         @(negedge clk); #1;
         chk($sformatf("st_addr%0d", k), bus.ub_address, 10'h155);
         chk($sformatf("st_quiet%0d", k), {bus.cmp_req_ready, bus.fifo_req_ready,
             bus.cmp_rsp_valid, bus.fifo_rsp_valid}, 0);
      end
      done_delay = 1;
      @(negedge clk); #1;               // T8
      chk("st_rsp", {bus.cmp_rsp_valid, bus.fifo_rsp_valid}, 2'b10);
      chk("st_next_acc", bus.fifo_req_ready, 1);
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      @(negedge clk); #1;
      chk("st_fifo_rsp", {bus.cmp_rsp_valid, bus.fifo_rsp_valid}, 2'b01);
      @(negedge clk); #1;
      chk("st_single", {bus.cmp_rsp_valid, bus.fifo_rsp_valid}, 0);

`ifdef UB_ARB_TIMEOUT_EN
      // Buffer never answers: abort after 15 WAIT cycles.
      no_done = 1;
      bus.cmp_req_valid = 1; bus.cmp_req_write = 0; bus.cmp_req_addr = 10'h077;
      @(negedge clk);
      idle_inputs();
      for (int k = 2; k <= 16; k++) begin
         @(negedge clk); #1;
         chk($sformatf("to_wait%0d", k), bus.cmp_rsp_valid, 0);
      end
      @(negedge clk); #1;
      chk("to_rsp", {bus.cmp_rsp_valid, bus.rsp_err, bus.err_sticky}, 3'b111);
      no_done = 0;
      @(negedge clk);
      bus.fifo_req_valid = 1; bus.fifo_req_write = 1; bus.fifo_req_addr = 10'h033;
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      @(negedge clk); #1;
      chk("to_norm", {bus.fifo_rsp_valid, bus.rsp_err, bus.err_sticky}, 3'b101);
`else
      chk("no_sticky", {bus.rsp_err, bus.err_sticky}, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
